// File: rtl/lt_pkg.sv
// Shared types and codes for the DP source link-training block.
// State codes are Gray along the main training path.
package lt_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'b0000,
    ST_WR_CFG    = 4'b0001,
    ST_WR_TPS1   = 4'b0011,
    ST_WAIT      = 4'b0010,
    ST_RD_STATUS = 4'b0110,
    ST_EVAL      = 4'b0111,
    ST_ERR_WAIT  = 4'b0101,
    ST_WR_DRIVE  = 4'b0100,
    ST_DONE      = 4'b1100,
    ST_FAIL      = 4'b1101
  } lt_state_e;

  localparam logic [1:0] AUX_WR_CFG    = 2'b00;
  localparam logic [1:0] AUX_WR_TPS1   = 2'b01;
  localparam logic [1:0] AUX_WR_DRIVE  = 2'b10;
  localparam logic [1:0] AUX_RD_STATUS = 2'b11;

  localparam logic [7:0] BW_RBR  = 8'h06;
  localparam logic [7:0] BW_HBR  = 8'h0A;
  localparam logic [7:0] BW_HBR2 = 8'h14;
  localparam logic [7:0] BW_HBR3 = 8'h1E;

  localparam logic [1:0] LC_1 = 2'b00;
  localparam logic [1:0] LC_2 = 2'b01;
  localparam logic [1:0] LC_4 = 2'b11;

  // The reserved code 2'b10 falls back to a single lane.
  function automatic logic [3:0] lane_mask(input logic [1:0] lc);
    case (lc)
      LC_2:    return 4'b0011;
      LC_4:    return 4'b1111;
      default: return 4'b0001;
    endcase
  endfunction

endpackage

// File: rtl/lt_wait_timer.sv
// Down-counter: load sets the count, en decrements toward zero, expired is high at zero.
// A load of N-1 gives an expiry on the Nth enabled cycle.
module lt_wait_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/cr_lt_fsm.sv
// Clock-recovery link-training FSM: drives AUX writes/reads, evaluates CR_DONE, applies cr_err_chk decisions.
// AUX requests are held until ack; an errored ack drops the request one cycle before reissue.
module cr_lt_fsm
  import lt_pkg::*;
#(
  parameter int CR_WAIT   = 100,
  parameter int AUX_RETRY = 3,
  parameter int ERR_TMO   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       config_param_vld,
  input  logic [7:0] link_bw_cr,
  input  logic [1:0] link_lc_cr,
  output logic       aux_req,
  output logic [1:0] aux_op,
  input  logic       aux_ack,
  input  logic       aux_err,
  input  logic [3:0] aux_cr_done,
  input  logic [7:0] aux_adj_vtg,
  input  logic [7:0] aux_adj_pre,
  output logic [7:0] phy_bw,
  output logic [1:0] phy_lc,
  output logic [7:0] phy_vtg,
  output logic [7:0] phy_pre,
  output logic       phy_tps1,
  output logic       cr_chk_start,
  output logic [7:0] adj_vtg,
  output logic [7:0] adj_pre,
  output logic       cr_completed,
  output logic       fsm_cr_failed,
  input  logic [7:0] new_bw_cr,
  input  logic [1:0] new_lc_cr,
  input  logic       err_cr_failed,
  input  logic       drive_setting_flag,
  input  logic       bw_flag,
  input  logic       lc_flag
);

  localparam int TMAX = (CR_WAIT > ERR_TMO) ? CR_WAIT : ERR_TMO;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = $clog2(AUX_RETRY + 2);

  lt_state_e     state_q;
  logic          aux_req_q;
  logic [1:0]    aux_op_q;
  logic [7:0]    phy_bw_q, phy_vtg_q, phy_pre_q, adj_vtg_q, adj_pre_q;
  logic [1:0]    phy_lc_q;
  logic          phy_tps1_q, cr_chk_start_q, cr_completed_q, fsm_cr_failed_q;
  logic [3:0]    cr_done_q;
  logic [RW-1:0] retry_q;

  logic          tmr_load, tmr_en, tmr_expired;
  logic [TW-1:0] tmr_val;
  logic          lanes_ok, retry_last, good_ack;

  assign lanes_ok   = (cr_done_q & lane_mask(phy_lc_q)) == lane_mask(phy_lc_q);
  assign retry_last = (retry_q == RW'(AUX_RETRY));
  assign good_ack   = aux_req_q && aux_ack && !aux_err;
  assign tmr_en     = (state_q == ST_WAIT) || (state_q == ST_ERR_WAIT);

  // The timer is loaded on the transition into WAIT or ERR_WAIT.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = TW'(CR_WAIT - 1);
    if ((state_q == ST_WR_TPS1 || state_q == ST_WR_DRIVE) && good_ack) begin
      tmr_load = 1'b1;
    end else if (state_q == ST_EVAL && !lanes_ok) begin
      tmr_load = 1'b1;
      tmr_val  = TW'(ERR_TMO - 1);
    end
  end

  lt_wait_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .expired_o  (tmr_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      aux_req_q        <= 1'b0;
      aux_op_q         <= AUX_WR_CFG;
      phy_bw_q         <= '0;
      phy_lc_q         <= '0;
      phy_vtg_q        <= '0;
      phy_pre_q        <= '0;
      phy_tps1_q       <= 1'b0;
      adj_vtg_q        <= '0;
      adj_pre_q        <= '0;
      cr_done_q        <= '0;
      retry_q          <= '0;
      cr_chk_start_q   <= 1'b0;
      cr_completed_q   <= 1'b0;
      fsm_cr_failed_q  <= 1'b0;
    end else begin
      cr_chk_start_q  <= 1'b0;
      cr_completed_q  <= 1'b0;
      fsm_cr_failed_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (config_param_vld) begin
            phy_bw_q  <= link_bw_cr;
            phy_lc_q  <= link_lc_cr;
            phy_vtg_q <= '0;
            phy_pre_q <= '0;
            retry_q   <= '0;
            aux_req_q <= 1'b1;
            aux_op_q  <= AUX_WR_CFG;
            state_q   <= ST_WR_CFG;
          end
        end
        ST_WR_CFG, ST_WR_TPS1, ST_RD_STATUS, ST_WR_DRIVE: begin
          if (!aux_req_q) begin
            aux_req_q <= 1'b1;
          end else if (aux_ack && aux_err) begin
            aux_req_q <= 1'b0;
            if (retry_last) begin
              retry_q         <= '0;
              phy_tps1_q      <= 1'b0;
              fsm_cr_failed_q <= 1'b1;
              state_q         <= ST_FAIL;
            end else begin
              retry_q <= retry_q + 1'b1;
            end
          end else if (aux_ack) begin
            retry_q <= '0;
            case (state_q)
              ST_WR_CFG: begin
                aux_op_q   <= AUX_WR_TPS1;
                phy_tps1_q <= 1'b1;
                state_q    <= ST_WR_TPS1;
              end
              ST_RD_STATUS: begin
                adj_vtg_q <= aux_adj_vtg;
                adj_pre_q <= aux_adj_pre;
                cr_done_q <= aux_cr_done;
                aux_req_q <= 1'b0;
                state_q   <= ST_EVAL;
              end
              default: begin
                aux_req_q <= 1'b0;
                state_q   <= ST_WAIT;
              end
            endcase
          end
        end
        ST_WAIT: begin
          if (tmr_expired) begin
            aux_req_q <= 1'b1;
            aux_op_q  <= AUX_RD_STATUS;
            state_q   <= ST_RD_STATUS;
          end
        end
        ST_EVAL: begin
          if (lanes_ok) begin
            cr_completed_q <= 1'b1;
            state_q        <= ST_DONE;
          end else begin
            cr_chk_start_q <= 1'b1;
            state_q        <= ST_ERR_WAIT;
          end
        end
        ST_ERR_WAIT: begin
          if (err_cr_failed || (!bw_flag && !drive_setting_flag && tmr_expired)) begin
            phy_tps1_q      <= 1'b0;
            fsm_cr_failed_q <= 1'b1;
            state_q         <= ST_FAIL;
          end else if (bw_flag) begin
            phy_bw_q <= new_bw_cr;
            if (lc_flag) phy_lc_q <= new_lc_cr;
            phy_vtg_q <= '0;
            phy_pre_q <= '0;
            aux_req_q <= 1'b1;
            aux_op_q  <= AUX_WR_CFG;
            state_q   <= ST_WR_CFG;
          end else if (drive_setting_flag) begin
            phy_vtg_q <= adj_vtg_q;
            phy_pre_q <= adj_pre_q;
            aux_req_q <= 1'b1;
            aux_op_q  <= AUX_WR_DRIVE;
            state_q   <= ST_WR_DRIVE;
          end
        end
        ST_DONE, ST_FAIL: state_q <= ST_IDLE;
        default:          state_q <= ST_IDLE;
      endcase
    end
  end

  assign aux_req       = aux_req_q;
  assign aux_op        = aux_op_q;
  assign phy_bw        = phy_bw_q;
  assign phy_lc        = phy_lc_q;
  assign phy_vtg       = phy_vtg_q;
  assign phy_pre       = phy_pre_q;
  assign phy_tps1      = phy_tps1_q;
  assign cr_chk_start  = cr_chk_start_q;
  assign adj_vtg       = adj_vtg_q;
  assign adj_pre       = adj_pre_q;
  assign cr_completed  = cr_completed_q;
  assign fsm_cr_failed = fsm_cr_failed_q;

endmodule

// File: doc/cr_lt_fsm.md
# cr_lt_fsm

Clock-recovery (CR) link-training state machine of the DP source link-training block. It sits directly upstream of `cr_err_chk`. It performs these steps:
- programs link rate and lane count, enables training pattern 1 (TPS1), and writes drive settings over an abstract AUX request/acknowledge channel;
- after a fixed interval, reads lane status;
- on a CR miss, hands the sink's adjust request to `cr_err_chk` and applies that block's decision: new drive levels, lower bandwidth, fewer lanes, or fail.

## Interface
Parameters:
- CR_WAIT, 100: cycles between a completed TPS1/drive write and the status read (≥1).
- AUX_RETRY, 3: AUX error retries per request before failing.
- ERR_TMO, 8: cycles allowed for a `cr_err_chk` decision after `cr_chk_start`.

Ports (reset rst_n, asynchronous, active-low; clock clk):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- config_param_vld  in  1  start pulse; also latched by `cr_err_chk`
- link_bw_cr  in  8  initial link rate code
- link_lc_cr  in  2  initial lane count (00=1, 01=2, 11=4)
- aux_req  out  1  AUX request, held until ack
- aux_op  out  2  00 WR_CFG, 01 WR_TPS1, 10 WR_DRIVE, 11 RD_STATUS
- aux_ack  in  1  one-cycle completion of the current request
- aux_err  in  1  qualifies aux_ack as failed
- aux_cr_done  in  4  per-lane CR_DONE, valid with an RD_STATUS ack
- aux_adj_vtg  in  8  sink voltage-swing request, 2 bits/lane, valid with an RD_STATUS ack
- aux_adj_pre  in  8  sink pre-emphasis request, 2 bits/lane, valid with an RD_STATUS ack
- phy_bw  out  8  current link rate (AUX/PHY payload)
- phy_lc  out  2  current lane count
- phy_vtg  out  8  current voltage swing
- phy_pre  out  8  current pre-emphasis
- phy_tps1  out  1  TPS1 enable
- cr_chk_start  out  1  one-cycle pulse to `cr_err_chk`
- adj_vtg  out  8  latched sink voltage request, held stable
- adj_pre  out  8  latched sink pre-emphasis request, held stable
- cr_completed  out  1  one-cycle success pulse
- fsm_cr_failed  out  1  one-cycle failure pulse
- new_bw_cr  in  8  reduced link rate from `cr_err_chk`
- new_lc_cr  in  2  reduced lane count from `cr_err_chk`
- err_cr_failed  in  1  fail decision from `cr_err_chk`
- drive_setting_flag  in  1  "apply new drive levels" decision
- bw_flag  in  1  "apply new link rate" decision
- lc_flag  in  1  "apply new lane count" decision

## Operation
All outputs reset to 0; state resets to IDLE.

States and transitions:
- IDLE: on config_param_vld, load phy_bw←link_bw_cr and phy_lc←link_lc_cr; clear phy_vtg and phy_pre; go to WR_CFG. config_param_vld outside IDLE is ignored.
- WR_CFG: aux_op=00. On a good ack, go to WR_TPS1.
- WR_TPS1: phy_tps1←1, aux_op=01. On a good ack, go to WAIT.
- WAIT: count CR_WAIT cycles, then go to RD_STATUS.
- RD_STATUS: aux_op=11. On a good ack, latch adj_vtg and adj_pre from aux_adj_*, then go to EVAL.
- EVAL: compare the active-lane CR_DONE bits. Lane mask is 0001 for lc=00 or 10 (10 is treated as 1 lane), 0011 for lc=01, 1111 for lc=11.
  - All active lanes done: go to DONE.
  - Otherwise: go to ERR_WAIT and pulse cr_chk_start on that transition.
- ERR_WAIT: act on the first decision seen, in this priority order:
  1. err_cr_failed: go to FAIL.
  2. bw_flag: phy_bw←new_bw_cr; if lc_flag, also phy_lc←new_lc_cr; clear phy_vtg and phy_pre; go to WR_CFG.
  3. drive_setting_flag: phy_vtg←adj_vtg, phy_pre←adj_pre; go to WR_DRIVE.
  4. No decision within ERR_TMO cycles: go to FAIL.
- WR_DRIVE: aux_op=10. On a good ack, go to WAIT.
- DONE: pulse cr_completed for one cycle; phy_tps1 stays 1; go to IDLE.
- FAIL: pulse fsm_cr_failed for one cycle; clear phy_tps1; go to IDLE.

AUX handshake:
- aux_req rises on entry to any AUX state; aux_op and the phy_* payload stay stable until aux_ack.
- aux_ack with aux_err: drop aux_req for 1 cycle, then reissue.
- The (AUX_RETRY+1)th consecutive error goes to FAIL. The retry counter clears on every good ack.

## Timing
- Start to first aux_req: 1 cycle (aux_req is registered high the cycle after config_param_vld).
- cr_chk_start is asserted the cycle after EVAL; adj_vtg and adj_pre are already valid that cycle.
- Expected `cr_err_chk` decision latency after cr_chk_start:
  - drive_setting_flag: +3 cycles
  - bw_flag: +4 cycles
  - lc_flag or err_cr_failed: +6 cycles
  - ERR_TMO=8 covers all of these.
- Flags arriving in states other than ERR_WAIT are ignored.
- The reset input to `cr_err_chk` counters is cr_completed/fsm_cr_failed; both are single-cycle and mutually exclusive.
- An aux_ack arriving in the same cycle that aux_req rises is valid.
- Reset mid-operation: state returns to IDLE and all outputs clear immediately.

## Structure
- Package `lt_pkg` holds:
  - the state enum (Gray encoded);
  - aux_op constants;
  - link-rate codes: RBR 8'h06, HBR 8'h0A, HBR2 8'h14, HBR3 8'h1E;
  - the lane-count codes.
- Sub-module `lt_wait_timer` (load/count/expire) provides both the WAIT interval and the ERR_WAIT timeout.

## Test plan
- HBR2 ×4 lanes, all lanes report CR_DONE=1111 on the first read -> cr_completed pulses. Exactly 3 AUX requests (00, 01, 11); WAIT lasts 100 cycles.
- First read 0011 with adj_vtg=8'h55; `cr_err_chk` model asserts drive_setting_flag at +3 -> phy_vtg=8'h55, WR_DRIVE then WAIT/RD_STATUS repeat; second read 1111 -> pass.
- Miss, then bw_flag with new_bw_cr=8'h0A -> phy_bw=8'h0A, phy_vtg=0, retraining restarts at WR_CFG.
- Miss, then bw_flag+lc_flag with new_bw_cr=8'h14, new_lc_cr=01 -> phy_lc=01; later reads check lanes 0-1 only.
- Four consecutive aux_err acks on WR_TPS1 -> fsm_cr_failed pulse, phy_tps1=0. No decision within 8 cycles in ERR_WAIT -> FAIL. Reset asserted during WAIT -> all outputs 0 in the same cycle.
